madd_seq: RTL and testbench
===========================

MADD_SEQ -- requirements
Module: madd_seq

Interface
REQ-001 Parameter RUN_CYCLES, default 18, number of cycles dm_run is held high per command.
REQ-002 Parameter FIFO_DEPTH, default 4, entry buffer depth (power of two, >=2).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 cmd_valid / cmd_ready  in / out  1 / 1  command handshake; cmd_ready = 1 only in IDLE.
REQ-006 cmd_op  in  2  00 MIN, 01 MAX, 10 MADD, 11 illegal.
REQ-007 cmd_count  in  4  number of entries to load minus one (1..16 entries).
REQ-008 ent_valid / ent_ready  in / out  1 / 1  entry handshake; ent_ready = !fifo_full.
REQ-009 ent_index, ent_data  in  4, 4  entry payload.
REQ-010 dm_rst_n  out  1  active-low clear to the downstream MADD engine.
REQ-011 dm_index, dm_data, dm_insn, dm_load, dm_run  out  4, 4, 2, 1, 1  engine drive, all registered.
REQ-012 dm_out, dm_out_top  in  8, 4  engine result.
REQ-013 res_valid / res_ready  out / in  1 / 1  result handshake.
REQ-014 res_value, res_op  out  12, 2  {dm_out_top, dm_out} and the originating op.
REQ-015 busy, err  out  1, 1  busy = state != IDLE; err sticky illegal-op flag.

Function
REQ-016 States SHALL be IDLE, CLEAR, INIT, LOAD, RUN, DRAIN, RESULT.
REQ-017 IDLE: on cmd_valid&&cmd_ready with op!=11, latch op and cmd_count, go CLEAR; with op==11, set err, stay IDLE.
REQ-018 CLEAR (1 cycle): dm_rst_n=0, dm_load=0, dm_run=0; go INIT.
REQ-019 INIT (1 cycle): dm_rst_n=1, dm_insn=op, dm_load=0, dm_run=0; go LOAD.
REQ-020 LOAD: each cycle FIFO non-empty, pop one entry, drive dm_load=1, dm_insn=op, dm_index/dm_data=entry; decrement remaining count.
REQ-021 LOAD stall (FIFO empty): drive idle code dm_insn=11, dm_load=0, dm_run=0; never repeat a load, never re-issue INIT code.
REQ-022 After cmd_count+1 pops, go RUN; entries beyond that stay in FIFO for the next command.
REQ-023 RUN: dm_run=1, dm_load=0, dm_insn=op for exactly RUN_CYCLES cycles (counter width ceil(log2(RUN_CYCLES+1))); go DRAIN.
REQ-024 DRAIN (1 cycle): idle code; at end capture res_value={dm_out_top,dm_out}, res_op=op; go RESULT.
REQ-025 RESULT: res_valid=1, res_value/res_op stable until res_valid&&res_ready; then res_valid=0, go IDLE same edge.
REQ-026 Latency: command accepted at edge T with N entries already buffered: CLEAR T+1, first load T+3, RUN starts T+3+N, res_valid at T+4+N+RUN_CYCLES.
REQ-027 FIFO push and pop in the same cycle SHALL be allowed when full (ent_ready stays 0 when full; push only when ent_ready).
REQ-028 FIFO pointers wrap modulo FIFO_DEPTH; occupancy counter width log2(FIFO_DEPTH)+1.
REQ-029 Entries may be pushed in any state, including before the command.
REQ-030 err SHALL clear only on rst.

Reset
REQ-031 rst SHALL, from any state, go IDLE and flush FIFO on the next edge.
REQ-032 Reset values: dm_rst_n=0, dm_load=0, dm_run=0, dm_insn=11, dm_index=0, dm_data=0, res_valid=0, res_value=0, res_op=0, err=0, busy=0.
REQ-033 First cycle after rst deasserts: cmd_ready=1, ent_ready=1, dm_rst_n=1.

Structure
REQ-034 Shared package SHALL hold op codes (OP_MIN, OP_MAX, OP_MADD, OP_ILL), idle code 11, and the state enumeration.
REQ-035 Entry buffer SHALL be sub-module madd_fifo (8-bit payload, FIFO_DEPTH, full/empty, synchronous reset).

Verification
REQ-036 Preload 4 entries, cmd MADD count=3 -> exactly 4 dm_load pulses with insn=10 in FIFO order, 18 dm_run cycles, res_valid at T+26.
REQ-037 Cmd MIN count=1 with FIFO empty, push 2 entries 5 cycles later -> idle code (insn=11) during stall, then 2 loads, no INIT repeat.
REQ-038 Cmd op=11 -> err=1, busy stays 0, no dm_* activity; later MAX cmd completes normally with err still 1.
REQ-039 Push 6 entries with FIFO_DEPTH=4 and no command -> ent_ready=0 after 4th; 5th/6th held; simultaneous pop/push at full keeps occupancy 4.
REQ-040 Hold res_ready=0 for 10 cycles in RESULT -> res_valid/res_value stable; cmd_ready=0 throughout.
REQ-041 Assert rst mid-RUN -> next cycle IDLE, dm_run=0, dm_rst_n=0, FIFO empty, res_valid=0.

Source files
------------

// File: rtl/madd_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : madd_seq_pkg                                           |
// | Description : Op codes, engine idle code and sequencer state set.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package madd_seq_pkg;

    typedef enum logic [1:0] {
        OP_MIN  = 2'b00,
        OP_MAX  = 2'b01,
        OP_MADD = 2'b10,
        OP_ILL  = 2'b11
    } op_e;

    // Instruction code that leaves the engine untouched for a cycle.
    localparam logic [1:0] c_insn_idle = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_INIT   = 3'd2,
        S_LOAD   = 3'd3,
        S_RUN    = 3'd4,
        S_DRAIN  = 3'd5,
        S_RESULT = 3'd6
    } state_e;

endpackage
`default_nettype wire

// File: rtl/madd_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : madd_fifo                                              |
// | Description : Entry buffer, first-word fall-through, sync reset.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module madd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int               c_ptr_w    = $clog2(DEPTH);
    localparam logic [c_ptr_w:0] c_full_cnt = (c_ptr_w + 1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full     = (r_count == c_full_cnt);
    assign o_empty    = (r_count == '0);
    assign o_pop_data = r_mem[r_rd_ptr];
    assign w_do_pop   = i_pop && !o_empty;
    // A full buffer still accepts a write when a read frees a slot on the same edge.
    assign w_do_push  = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/madd_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : madd_seq                                               |
// | Description : Command sequencer feeding buffered entries to a MADD   |
// |               engine and returning its result.                       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module madd_seq
    import madd_seq_pkg::*;
#(
    parameter int RUN_CYCLES = 18,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [3:0]  cmd_count,
    input  logic        ent_valid,
    output logic        ent_ready,
    input  logic [3:0]  ent_index,
    input  logic [3:0]  ent_data,
    output logic        dm_rst_n,
    output logic [3:0]  dm_index,
    output logic [3:0]  dm_data,
    output logic [1:0]  dm_insn,
    output logic        dm_load,
    output logic        dm_run,
    input  logic [7:0]  dm_out,
    input  logic [3:0]  dm_out_top,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [11:0] res_value,
    output logic [1:0]  res_op,
    output logic        busy,
    output logic        err
);

    localparam int                 c_run_w    = $clog2(RUN_CYCLES + 1);
    localparam logic [c_run_w-1:0] c_run_load = c_run_w'(RUN_CYCLES);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [1:0]         r_op;
    logic [3:0]         r_remaining;
    logic [c_run_w-1:0] r_run_cnt;

    logic        r_dm_rst_n;
    logic [3:0]  r_dm_index;
    logic [3:0]  r_dm_data;
    logic [1:0]  r_dm_insn;
    logic        r_dm_load;
    logic        r_dm_run;
    logic        r_res_valid;
    logic [11:0] r_res_value;
    logic [1:0]  r_res_op;
    logic        r_err;

    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic [7:0]  w_fifo_data;
    logic        w_pop;
    logic        w_cmd_fire;

    madd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (ent_valid && ent_ready),
        .i_push_data ({ent_index, ent_data}),
        .i_pop       (w_pop),
        .o_pop_data  (w_fifo_data),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    assign cmd_ready  = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign ent_ready  = !w_fifo_full;
    assign w_cmd_fire = cmd_valid && cmd_ready;
    assign w_pop      = (r_state == S_LOAD) && !w_fifo_empty;

    assign dm_rst_n  = r_dm_rst_n;
    assign dm_index  = r_dm_index;
    assign dm_data   = r_dm_data;
    assign dm_insn   = r_dm_insn;
    assign dm_load   = r_dm_load;
    assign dm_run    = r_dm_run;
    assign res_valid = r_res_valid;
    assign res_value = r_res_value;
    assign res_op    = r_res_op;
    assign err       = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_cmd_fire && cmd_op != OP_ILL) w_state_nxt = S_CLEAR;
            S_CLEAR:  w_state_nxt = S_INIT;
            S_INIT:   w_state_nxt = S_LOAD;
            S_LOAD:   if (w_pop && r_remaining == 4'd0) w_state_nxt = S_RUN;
            S_RUN:    if (r_run_cnt == c_run_w'(1)) w_state_nxt = S_DRAIN;
            S_DRAIN:  w_state_nxt = S_RESULT;
            S_RESULT: if (r_res_valid && res_ready) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Engine drive is registered from the current state, so the engine sees
    // each phase one cycle after the sequencer enters it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op        <= 2'b00;
            r_remaining <= 4'd0;
            r_run_cnt   <= '0;
            r_dm_rst_n  <= 1'b0;
            r_dm_index  <= 4'd0;
            r_dm_data   <= 4'd0;
            r_dm_insn   <= c_insn_idle;
            r_dm_load   <= 1'b0;
            r_dm_run    <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_value <= 12'd0;
            r_res_op    <= 2'b00;
            r_err       <= 1'b0;
        end else begin
            r_dm_rst_n <= 1'b1;
            r_dm_load  <= 1'b0;
            r_dm_run   <= 1'b0;
            r_dm_insn  <= c_insn_idle;
            case (r_state)
                S_IDLE: begin
                    if (w_cmd_fire) begin
                        if (cmd_op == OP_ILL) begin
                            r_err <= 1'b1;
                        end else begin
                            r_op        <= cmd_op;
                            r_remaining <= cmd_count;
                        end
                    end
                end
                S_CLEAR: r_dm_rst_n <= 1'b0;
                S_INIT:  r_dm_insn  <= r_op;
                S_LOAD: begin
                    if (w_pop) begin
                        r_dm_load   <= 1'b1;
                        r_dm_insn   <= r_op;
                        r_dm_index  <= w_fifo_data[7:4];
                        r_dm_data   <= w_fifo_data[3:0];
                        r_remaining <= r_remaining - 4'd1;
                        r_run_cnt   <= c_run_load;
                    end
                end
                S_RUN: begin
                    r_dm_run  <= 1'b1;
                    r_dm_insn <= r_op;
                    r_run_cnt <= r_run_cnt - 1'b1;
                end
                S_RESULT: begin
                    // First RESULT cycle is the engine's drain cycle; capture at its end.
                    if (!r_res_valid) begin
                        r_res_valid <= 1'b1;
                        r_res_value <= {dm_out_top, dm_out};
                        r_res_op    <= r_op;
                    end else if (res_ready) begin
                        r_res_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_madd_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_madd_seq                                            |
// | Description : Directed bench with a timeline model of the sequencer. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_madd_seq;
    import madd_seq_pkg::*;

    localparam int c_run   = 18;
    localparam int c_depth = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [3:0]  cmd_count;
    logic        ent_valid, ent_ready;
    logic [3:0]  ent_index, ent_data;
    logic        dm_rst_n, dm_load, dm_run;
    logic [3:0]  dm_index, dm_data;
    logic [1:0]  dm_insn;
    logic [7:0]  dm_out;
    logic [3:0]  dm_out_top;
    logic        res_valid, res_ready;
    logic [11:0] res_value;
    logic [1:0]  res_op;
    logic        busy, err;

    madd_seq #(
        .RUN_CYCLES (c_run),
        .FIFO_DEPTH (c_depth)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_count  (cmd_count),
        .ent_valid  (ent_valid),
        .ent_ready  (ent_ready),
        .ent_index  (ent_index),
        .ent_data   (ent_data),
        .dm_rst_n   (dm_rst_n),
        .dm_index   (dm_index),
        .dm_data    (dm_data),
        .dm_insn    (dm_insn),
        .dm_load    (dm_load),
        .dm_run     (dm_run),
        .dm_out     (dm_out),
        .dm_out_top (dm_out_top),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_value  (res_value),
        .res_op     (res_op),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endfunction

    // Model: expected engine drive follows from the accept edge and the entry queue.
    logic [7:0]  m_q [$];
    bit          m_valid = 0;
    bit          m_busy, m_err;
    int          m_acc, m_left, m_last;
    logic [1:0]  m_op;
    logic        x_rst_n, x_load, x_run, x_resv;
    logic [1:0]  x_insn, x_resop;
    logic [3:0]  x_idx, x_dat;
    logic [11:0] x_resval;

    logic [7:0]  log_loads [$];
    int          log_runs, log_init, res_rise, acc_cyc;
    logic        prev_resv = 1'b0;

    always @(posedge clk) begin
        logic       s_rst, s_cv, s_cr, s_ev, s_rr;
        logic [1:0] s_op;
        logic [3:0] s_cnt, s_idx, s_dat, s_top;
        logic [7:0] s_out, s_ent;
        int         sb;
        s_rst = rst;  s_cv = cmd_valid; s_cr = cmd_ready; s_op = cmd_op; s_cnt = cmd_count;
        s_ev = ent_valid; s_idx = ent_index; s_dat = ent_data; s_rr = res_ready;
        s_out = dm_out; s_top = dm_out_top;
        cyc++;
        if (!s_rst && s_cv && s_cr && s_op != 2'b11) begin
            acc_cyc = cyc; log_loads.delete(); log_runs = 0; log_init = 0; res_rise = -1;
        end
        if (s_rst) begin
            m_q.delete(); m_busy = 0; m_err = 0; m_valid = 1;
            x_rst_n = 0; x_load = 0; x_run = 0; x_insn = 2'b11; x_idx = 0; x_dat = 0;
            x_resv = 0; x_resval = 0; x_resop = 0;
        end else begin
            sb = m_q.size();
            x_rst_n = 1; x_load = 0; x_run = 0; x_insn = 2'b11;
            if (!m_busy) begin
                if (s_cv) begin
                    if (s_op == 2'b11) m_err = 1;
                    else begin
                        m_busy = 1; m_acc = cyc; m_op = s_op;
                        m_left = int'(s_cnt) + 1; m_last = -1000;
                    end
                end
            end else if (cyc == m_acc + 1) x_rst_n = 0;
            else if (cyc == m_acc + 2) x_insn = m_op;
            else if (m_left > 0) begin
                if (sb > 0) begin
                    s_ent = m_q.pop_front();
                    x_load = 1; x_insn = m_op; x_idx = s_ent[7:4]; x_dat = s_ent[3:0];
                    m_left--;
                    if (m_left == 0) m_last = cyc;
                end
            end else if (cyc <= m_last + c_run) begin
                x_run = 1; x_insn = m_op;
            end else if (cyc == m_last + c_run + 2) begin
                x_resv = 1; x_resval = {s_top, s_out}; x_resop = m_op;
            end else if (x_resv && s_rr) begin
                x_resv = 0; m_busy = 0;
            end
            if (s_ev && sb < c_depth) m_q.push_back({s_idx, s_dat});
        end
        #1;
        if (m_valid) begin
            chk("dm_rst_n", dm_rst_n, x_rst_n);
            chk("dm_load", dm_load, x_load);
            chk("dm_run", dm_run, x_run);
            chk("dm_insn", dm_insn, x_insn);
            chk("dm_index", dm_index, x_idx);
            chk("dm_data", dm_data, x_dat);
            chk("res_valid", res_valid, x_resv);
            chk("res_value", res_value, x_resval);
            chk("res_op", res_op, x_resop);
            chk("busy", busy, m_busy);
            chk("cmd_ready", cmd_ready, !m_busy);
            chk("ent_ready", ent_ready, m_q.size() < c_depth);
            chk("err", err, m_err);
        end
        if (dm_load) log_loads.push_back({dm_index, dm_data});
        if (dm_run) log_runs++;
        if (busy && dm_rst_n && !dm_load && !dm_run && dm_insn != 2'b11) log_init++;
        if (res_valid && !prev_resv) res_rise = cyc;
        prev_resv = res_valid;
    end

    logic [7:0] stim [12];

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_range(input int first, input int n);
        for (int k = 0; k < n; k++) begin
            int w = 0;
            ent_valid = 1'b1;
            {ent_index, ent_data} = stim[first + k];
            while (!ent_ready && w < 300) begin @(negedge clk); w++; end
            chk("push_wait", w < 300, 1);
            @(negedge clk);
        end
        ent_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [3:0] cnt);
        int w = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_count = cnt;
        while (!cmd_ready && w < 300) begin @(negedge clk); w++; end
        chk("cmd_wait", w < 300, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_res();
        int w = 0;
        while (!res_valid && w < 200) begin @(negedge clk); w++; end
        chk("res_wait", w < 200, 1);
    endtask

    initial begin
        stim = '{8'h19, 8'h28, 8'h37, 8'h46, 8'h55, 8'h64,
                 8'h73, 8'h82, 8'h91, 8'hA1, 8'hB2, 8'hC3};
        cmd_valid = 0; cmd_op = 0; cmd_count = 0;
        ent_valid = 0; ent_index = 0; ent_data = 0;
        res_ready = 1; dm_out = 8'hA5; dm_out_top = 4'h3;
        repeat (3) @(negedge clk);
        chk("rst_dm_insn", dm_insn, 2'b11);
        chk("rst_dm_rst_n", dm_rst_n, 0);
        chk("rst_busy", busy, 0);
        rst = 0;
        chk("post_rst_cmd_ready", cmd_ready, 1);
        chk("post_rst_ent_ready", ent_ready, 1);
        @(negedge clk);
        chk("post_rst_dm_rst_n", dm_rst_n, 1);

        // Preload until full, then MADD over four entries; extras refill the buffer.
        fork
            push_range(0, 6);
            begin
                tick(6);
                chk("full_ent_ready", ent_ready, 0);
                send_cmd(OP_MADD, 4'd3);
            end
        join
        wait_res();
        chk("a_load_count", log_loads.size(), 4);
        chk("a_load0", log_loads[0], 8'h19);
        chk("a_load1", log_loads[1], 8'h28);
        chk("a_load2", log_loads[2], 8'h37);
        chk("a_load3", log_loads[3], 8'h46);
        chk("a_runs", log_runs, 18);
        chk("a_latency", res_rise - acc_cyc, 26);
        chk("a_value", res_value, 12'h3A5);
        chk("a_op", res_op, 2'b10);
        chk("a_init_once", log_init, 1);
        tick(2);

        // Illegal op is flagged and ignored; the next MAX uses the two leftovers.
        dm_out = 8'h5C; dm_out_top = 4'h1;
        send_cmd(2'b11, 4'd0);
        tick(2);
        chk("b_err", err, 1);
        chk("b_busy", busy, 0);
        send_cmd(OP_MAX, 4'd1);
        wait_res();
        chk("b_load_count", log_loads.size(), 2);
        chk("b_load0", log_loads[0], 8'h55);
        chk("b_load1", log_loads[1], 8'h64);
        chk("b_latency", res_rise - acc_cyc, 24);
        chk("b_value", res_value, 12'h15C);
        chk("b_op", res_op, 2'b01);
        chk("b_err_sticky", err, 1);
        tick(2);

        // MIN with an empty buffer stalls until entries arrive; result held back.
        res_ready = 0; dm_out = 8'h0F; dm_out_top = 4'hE;
        send_cmd(OP_MIN, 4'd1);
        tick(5);
        push_range(6, 2);
        wait_res();
        dm_out = 8'h00;
        for (int i = 0; i < 10; i++) begin
            chk("c_hold_valid", res_valid, 1);
            chk("c_hold_value", res_value, 12'hE0F);
            chk("c_hold_cmd_ready", cmd_ready, 0);
            tick(1);
        end
        res_ready = 1;
        tick(2);
        chk("c_done_busy", busy, 0);
        chk("c_load0", log_loads[0], 8'h73);
        chk("c_load1", log_loads[1], 8'h82);
        chk("c_init_once", log_init, 1);

        // Reset in the middle of RUN flushes the buffer and returns to idle.
        push_range(8, 3);
        send_cmd(OP_MADD, 4'd0);
        begin
            int w = 0;
            while (!dm_run && w < 50) begin @(negedge clk); w++; end
            chk("d_run_wait", w < 50, 1);
        end
        tick(3);
        rst = 1;
        @(negedge clk);
        chk("d_rst_run", dm_run, 0);
        chk("d_rst_rst_n", dm_rst_n, 0);
        chk("d_rst_res_valid", res_valid, 0);
        chk("d_rst_busy", busy, 0);
        chk("d_rst_err", err, 0);
        rst = 0;
        tick(1);
        send_cmd(OP_MIN, 4'd0);
        tick(6);
        chk("d_flushed", log_loads.size(), 0);
        push_range(11, 1);
        wait_res();
        chk("d_load0", log_loads[0], 8'hC3);
        tick(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1);
    end

endmodule
`default_nettype wire
